// File: rtl/conv_filter_pkg.sv
// Shared constants for the 3x3 RGB convolution filter: tap indices,
// mode encodings and the identity kernel loaded at reset.
package conv_filter_pkg;

  localparam int NTAPS  = 9;

  localparam int TAP_UL = 0;
  localparam int TAP_U  = 1;
  localparam int TAP_UR = 2;
  localparam int TAP_L  = 3;
  localparam int TAP_C  = 4;
  localparam int TAP_R  = 5;
  localparam int TAP_DL = 6;
  localparam int TAP_D  = 7;
  localparam int TAP_DR = 8;

  typedef enum logic {
    MODE_BYPASS = 1'b0,
    MODE_CONV   = 1'b1
  } mode_e;

  localparam int IDENTITY_KERNEL [NTAPS] = '{0, 0, 0, 0, 1, 0, 0, 0, 0};

endpackage

// File: rtl/conv_sat_round.sv
// Final stage for one channel: round-half-up right shift of the signed sum,
// then clip into [0, 2^CH_W-1], flagging any clipping.
module conv_sat_round #(
  parameter int CH_W  = 4,
  parameter int SUM_W = 13
) (
  input  logic signed [SUM_W-1:0] sum,
  input  logic        [2:0]       shift,
  output logic        [CH_W-1:0]  result,
  output logic                    clip
);

  localparam logic signed [SUM_W:0] MAX_V = {{(SUM_W+1-CH_W){1'b0}}, {CH_W{1'b1}}};

  logic signed [SUM_W:0] bias;
  logic signed [SUM_W:0] biased;
  logic signed [SUM_W:0] shifted;

  // One guard bit so adding the rounding bias can never wrap.
  always_comb begin
    bias = '0;
    if (shift != 3'd0) bias[shift - 3'd1] = 1'b1;
    biased  = $signed({sum[SUM_W-1], sum}) + bias;
    shifted = biased >>> shift;
    result  = shifted[CH_W-1:0];
    clip    = 1'b0;
    if (shifted[SUM_W]) begin
      result = '0;
      clip   = 1'b1;
    end else if (shifted > MAX_V) begin
      result = '1;
      clip   = 1'b1;
    end
  end

endmodule

// File: rtl/conv3x3_rgb_filter.sv
// 3-stage 3x3 convolution over packed RGB windows with shadow/active
// coefficient banks: S1 multiply, S2 adder tree, S3 round/saturate.
module conv3x3_rgb_filter
  import conv_filter_pkg::*;
#(
  parameter int CH_W   = 4,
  parameter int NCH    = 3,
  parameter int COEF_W = 5
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [9*NCH*CH_W-1:0]     in_window,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [NCH*CH_W-1:0]       out_pixel,
  output logic                      sat_flag,
  input  logic                      mode,
  input  logic [2:0]                shift,
  input  logic                      coef_wr,
  input  logic [3:0]                coef_addr,
  input  logic [COEF_W-1:0]         coef_data,
  input  logic                      coef_commit
);

  localparam int PIX_W  = NCH * CH_W;
  localparam int PROD_W = CH_W + 1 + COEF_W;
  localparam int SUM_W  = CH_W + COEF_W + 4;

  // Handshake: a transfer happens on a rising edge where valid & ready are both
  // high; the whole pipe moves together, so in_ready is simply the advance enable.
  logic en;
  assign en       = ~out_valid | out_ready;
  assign in_ready = en;

  logic signed [COEF_W-1:0] shadow_q   [NTAPS];
  logic signed [COEF_W-1:0] active_q   [NTAPS];
  logic signed [COEF_W-1:0] shadow_nxt [NTAPS];
  logic signed [COEF_W-1:0] coef_use   [NTAPS];

  // A window accepted in the commit cycle already sees the new bank,
  // including a write landing in that same cycle.
  always_comb begin
    for (int k = 0; k < NTAPS; k++) begin
      shadow_nxt[k] = shadow_q[k];
      if (coef_wr && (int'(coef_addr) == k)) shadow_nxt[k] = coef_data;
      coef_use[k] = coef_commit ? shadow_nxt[k] : active_q[k];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < NTAPS; k++) begin
        shadow_q[k] <= COEF_W'(IDENTITY_KERNEL[k]);
        active_q[k] <= COEF_W'(IDENTITY_KERNEL[k]);
      end
    end else begin
      for (int k = 0; k < NTAPS; k++) shadow_q[k] <= shadow_nxt[k];
      if (coef_commit) begin
        for (int k = 0; k < NTAPS; k++) active_q[k] <= shadow_nxt[k];
      end
    end
  end

  logic signed [PROD_W-1:0] prod_d [NCH][NTAPS];
  logic signed [PROD_W-1:0] s1_prod [NCH][NTAPS];
  logic                     s1_valid;
  mode_e                    s1_mode;
  logic [2:0]               s1_shift;
  logic [PIX_W-1:0]         s1_centre;

  always_comb begin
    for (int c = 0; c < NCH; c++) begin
      for (int k = 0; k < NTAPS; k++) begin
        prod_d[c][k] = PROD_W'($signed({1'b0, in_window[k*PIX_W + PIX_W-1 - c*CH_W -: CH_W]}))
                     * PROD_W'(coef_use[k]);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid  <= 1'b0;
      s1_mode   <= MODE_BYPASS;
      s1_shift  <= '0;
      s1_centre <= '0;
      for (int c = 0; c < NCH; c++)
        for (int k = 0; k < NTAPS; k++) s1_prod[c][k] <= '0;
    end else if (en) begin
      s1_valid  <= in_valid;
      s1_mode   <= mode_e'(mode);
      s1_shift  <= shift;
      s1_centre <= in_window[TAP_C*PIX_W +: PIX_W];
      s1_prod   <= prod_d;
    end
  end

  logic signed [SUM_W-1:0] sum_d  [NCH];
  logic signed [SUM_W-1:0] s2_sum [NCH];
  logic                    s2_valid;
  mode_e                   s2_mode;
  logic [2:0]              s2_shift;
  logic [PIX_W-1:0]        s2_centre;

  always_comb begin
    for (int c = 0; c < NCH; c++) begin
      sum_d[c] = '0;
      for (int k = 0; k < NTAPS; k++) sum_d[c] = sum_d[c] + SUM_W'(s1_prod[c][k]);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s2_valid  <= 1'b0;
      s2_mode   <= MODE_BYPASS;
      s2_shift  <= '0;
      s2_centre <= '0;
      for (int c = 0; c < NCH; c++) s2_sum[c] <= '0;
    end else if (en) begin
      s2_valid  <= s1_valid;
      s2_mode   <= s1_mode;
      s2_shift  <= s1_shift;
      s2_centre <= s1_centre;
      s2_sum    <= sum_d;
    end
  end

  logic [PIX_W-1:0] conv_pixel;
  logic [NCH-1:0]   clip;

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    conv_sat_round #(.CH_W(CH_W), .SUM_W(SUM_W)) u_sat (
      .sum    (s2_sum[c]),
      .shift  (s2_shift),
      .result (conv_pixel[PIX_W-1 - c*CH_W -: CH_W]),
      .clip   (clip[c])
    );
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_pixel <= '0;
      sat_flag  <= 1'b0;
    end else if (en) begin
      out_valid <= s2_valid;
      if (s2_valid) begin
        out_pixel <= (s2_mode == MODE_BYPASS) ? s2_centre : conv_pixel;
        sat_flag  <= (s2_mode == MODE_CONV) && (|clip);
      end
    end
  end

endmodule

// File: tb/tb_conv3x3_rgb_filter.sv
// Bench for conv3x3_rgb_filter: directed kernels, back-pressure, commit
// boundary, mid-stream reset and random traffic against an arithmetic model.
`timescale 1ns/1ps
module tb_conv3x3_rgb_filter;

  localparam int CH_W   = 4;
  localparam int NCH    = 3;
  localparam int COEF_W = 5;
  localparam int PIX_W  = NCH * CH_W;
  localparam int WIN_W  = 9 * PIX_W;
  localparam int EXP_W  = PIX_W + 1;

  logic               clk = 1'b0;
  logic               reset;
  logic               in_valid;
  logic               in_ready;
  logic [WIN_W-1:0]   in_window;
  logic               out_valid;
  logic               out_ready;
  logic [PIX_W-1:0]   out_pixel;
  logic               sat_flag;
  logic               mode;
  logic [2:0]         shift;
  logic               coef_wr;
  logic [3:0]         coef_addr;
  logic [COEF_W-1:0]  coef_data;
  logic               coef_commit;

  int n_checks = 0;
  int n_errors = 0;
  logic [EXP_W-1:0] exp_q[$];
  int m_shadow[9];
  int m_active[9];
  bit fixed_en;
  logic [EXP_W-1:0] fixed_exp;
  int n_out = 0;
  bit saw_stall;
  bit holding;
  logic [EXP_W-1:0] held;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  conv3x3_rgb_filter #(.CH_W(CH_W), .NCH(NCH), .COEF_W(COEF_W)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_window(in_window),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pixel(out_pixel), .sat_flag(sat_flag),
    .mode(mode), .shift(shift),
    .coef_wr(coef_wr), .coef_addr(coef_addr), .coef_data(coef_data),
    .coef_commit(coef_commit)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [EXP_W-1:0] model(input logic [WIN_W-1:0] w, input int k[9],
                                             input bit m, input int s);
    logic [PIX_W-1:0] px;
    bit sat;
    int sum;
    int v;
    px  = '0;
    sat = 1'b0;
    if (!m) return {1'b0, w[4*PIX_W +: PIX_W]};
    for (int c = 0; c < NCH; c++) begin
      sum = 0;
      for (int t = 0; t < 9; t++) sum += k[t] * int'(w[t*PIX_W + PIX_W-1 - c*CH_W -: CH_W]);
      if (s > 0) sum = (sum + (1 << (s - 1))) >>> s;
      if (sum < 0) begin v = 0; sat = 1'b1; end
      else if (sum > (1 << CH_W) - 1) begin v = (1 << CH_W) - 1; sat = 1'b1; end
      else v = sum;
      px[PIX_W-1 - c*CH_W -: CH_W] = v[CH_W-1:0];
    end
    return {sat, px};
  endfunction

  function automatic logic [WIN_W-1:0] mkwin(input logic [PIX_W-1:0] centre,
                                             input logic [PIX_W-1:0] others);
    logic [WIN_W-1:0] w;
    for (int t = 0; t < 9; t++) w[t*PIX_W +: PIX_W] = (t == 4) ? centre : others;
    return w;
  endfunction

  // ---------------- driver tasks ----------------
  // Called just after a falling edge with inputs already driven.
  task automatic step(output bit acc);
    int nxt[9];
    int use_k[9];
    logic [EXP_W-1:0] e;
    #1;
    if (holding && out_valid) chk("hold_stable", {19'b0, sat_flag, out_pixel}, {19'b0, held});
    if (out_valid && out_ready) begin
      n_out++;
      chk("output_expected", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("out_pixel", {20'b0, out_pixel}, {20'b0, e[PIX_W-1:0]});
        chk("sat_flag", {31'b0, sat_flag}, {31'b0, e[PIX_W]});
      end
    end
    holding = out_valid && !out_ready;
    held    = {sat_flag, out_pixel};
    if (in_valid && !in_ready) saw_stall = 1'b1;
    nxt = m_shadow;
    if (coef_wr && coef_addr <= 4'd8) nxt[coef_addr] = int'($signed(coef_data));
    if (coef_commit) use_k = nxt;
    else use_k = m_active;
    acc = in_valid && in_ready;
    if (acc) exp_q.push_back(fixed_en ? fixed_exp : model(in_window, use_k, mode, int'(shift)));
    @(posedge clk);
    m_shadow = nxt;
    if (coef_commit) m_active = nxt;
    @(negedge clk);
  endtask

  task automatic send(input logic [WIN_W-1:0] w, input bit m, input logic [2:0] s);
    bit a;
    int n;
    a = 1'b0;
    n = 0;
    in_valid = 1'b1; in_window = w; mode = m; shift = s;
    while (!a && n < 50) begin step(a); n++; end
    chk("send_accepted", a, 1);
    in_valid = 1'b0; coef_wr = 1'b0; coef_commit = 1'b0;
  endtask

  task automatic write_coef(input int addr, input int val);
    bit a;
    coef_wr = 1'b1; coef_addr = addr[3:0]; coef_data = val[COEF_W-1:0];
    step(a);
    coef_wr = 1'b0;
  endtask

  task automatic commit_bank();
    bit a;
    coef_commit = 1'b1;
    step(a);
    coef_commit = 1'b0;
  endtask

  task automatic drain();
    bit a;
    int n;
    n = 0;
    in_valid = 1'b0; coef_wr = 1'b0; coef_commit = 1'b0; out_ready = 1'b1;
    while (exp_q.size() > 0 && n < 50) begin step(a); n++; end
    chk("drain_done", exp_q.size(), 0);
    for (int i = 0; i < 3; i++) step(a);
  endtask

  task automatic do_reset(input int cycles);
    reset = 1'b1;
    #1;
    chk("rst_out_valid", out_valid, 0);
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("rst_out_valid", out_valid, 0);
    end
    exp_q.delete();
    holding = 1'b0;
    for (int t = 0; t < 9; t++) begin
      m_shadow[t] = (t == 4) ? 1 : 0;
      m_active[t] = (t == 4) ? 1 : 0;
    end
    reset = 1'b0;
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [WIN_W-1:0] wins[6];
    bit a;
    int lat;
    int idx;
    int cyc;
    int n0;

    reset = 1'b1; in_valid = 1'b0; in_window = '0; out_ready = 1'b1;
    mode = 1'b1; shift = 3'd0; coef_wr = 1'b0; coef_addr = '0; coef_data = '0;
    coef_commit = 1'b0; fixed_en = 1'b0; fixed_exp = '0; saw_stall = 1'b0; holding = 1'b0;
    @(negedge clk);
    do_reset(2);
    chk("rst_out_pixel", {20'b0, out_pixel}, 32'h0);
    chk("rst_sat_flag", sat_flag, 0);
    chk("rst_in_ready", in_ready, 1);

    // Identity kernel after reset, with exact latency.
    fixed_en = 1'b1;
    fixed_exp = {1'b0, 12'hA53};
    send(mkwin(12'hA53, 12'hFFF), 1'b1, 3'd0);
    lat = 1;
    while (!out_valid && lat < 10) begin step(a); lat++; end
    chk("latency", lat, 3);
    drain();

    // Sharpen kernel, plus an out-of-range write that must be ignored.
    for (int t = 0; t < 9; t++) write_coef(t, (t == 4) ? 9 : -1);
    write_coef(9, 15);
    commit_bank();
    fixed_exp = {1'b0, 12'h777}; send(mkwin(12'h777, 12'h777), 1'b1, 3'd0);
    fixed_exp = {1'b1, 12'hF00}; send(mkwin(12'hF00, 12'h000), 1'b1, 3'd0);
    fixed_exp = {1'b1, 12'h000}; send(mkwin(12'h000, 12'hFFF), 1'b1, 3'd0);
    fixed_exp = {1'b0, 12'hA53}; send(mkwin(12'hA53, 12'h000), 1'b0, 3'd5);
    drain();

    // Box blur with shift 3.
    for (int t = 0; t < 9; t++) write_coef(t, 1);
    commit_bank();
    fixed_exp = {1'b0, 12'h999}; send(mkwin(12'h888, 12'h888), 1'b1, 3'd3);
    drain();

    // Back-pressure: six windows, out_ready low for five cycles mid-stream.
    fixed_en = 1'b0;
    for (int i = 0; i < 6; i++) wins[i] = {$urandom, $urandom, $urandom, $urandom};
    saw_stall = 1'b0;
    n0 = n_out;
    idx = 0;
    cyc = 0;
    shift = 3'($urandom_range(0, 7));
    mode = 1'b1;
    while ((idx < 6 || cyc < 9) && cyc < 100) begin
      out_ready = !(cyc >= 3 && cyc < 8);
      in_valid  = (idx < 6);
      in_window = wins[idx < 6 ? idx : 5];
      step(a);
      if (a) idx++;
      cyc++;
    end
    drain();
    chk("bp_in_ready_dropped", saw_stall, 1);
    chk("bp_output_count", n_out - n0, 6);

    // Commit boundary: A before the commit (blur), B in the commit cycle
    // (sharpen, last tap written in that same cycle).
    for (int t = 0; t < 8; t++) write_coef(t, (t == 4) ? 9 : -1);
    fixed_en = 1'b1;
    fixed_exp = {1'b0, 12'h999}; send(mkwin(12'h888, 12'h888), 1'b1, 3'd3);
    coef_wr = 1'b1; coef_addr = 4'd8; coef_data = 5'h1F; coef_commit = 1'b1;
    fixed_exp = {1'b0, 12'h111}; send(mkwin(12'h777, 12'h777), 1'b1, 3'd3);
    drain();

    // Random traffic with random kernel updates and back-pressure.
    fixed_en = 1'b0;
    for (int i = 0; i < 300; i++) begin
      in_valid    = ($urandom_range(0, 9) < 7);
      in_window   = {$urandom, $urandom, $urandom, $urandom};
      mode        = ($urandom_range(0, 9) < 8);
      shift       = 3'($urandom_range(0, 7));
      out_ready   = ($urandom_range(0, 3) != 0);
      coef_wr     = ($urandom_range(0, 4) == 0);
      coef_addr   = 4'($urandom_range(0, 10));
      coef_data   = 5'($urandom_range(0, 31));
      coef_commit = ($urandom_range(0, 19) == 0);
      step(a);
    end
    drain();

    // Reset with three windows in flight.
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) send({$urandom, $urandom, $urandom, $urandom}, 1'b1, 3'd1);
    do_reset(2);
    fixed_en = 1'b1;
    fixed_exp = {1'b0, 12'h5C3};
    send(mkwin(12'h5C3, 12'($urandom)), 1'b1, 3'd0);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/conv3x3_rgb_filter.md
CONV3X3_RGB_FILTER -- requirements
Module: conv3x3_rgb_filter

Interface
REQ-001 SHALL have parameter CH_W, default 4, bits per colour channel.
REQ-002 SHALL have parameter NCH, default 3, channels per pixel; channel 0 occupies the tap MSBs (R,G,B order).
REQ-003 SHALL have parameter COEF_W, default 5, signed two's-complement coefficient width.
REQ-004 SHALL have ports, one per line:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  window valid.
- in_ready  out  1  window accepted when in_valid & in_ready.
- in_window  in  9*NCH*CH_W  taps k=0..8 in raster order (UL,U,UR,L,C,R,DL,D,DR); tap k at bits [(k+1)*NCH*CH_W-1 : k*NCH*CH_W].
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts.
- out_pixel  out  NCH*CH_W  filtered pixel.
- sat_flag  out  1  qualified by out_valid; 1 if any channel clipped.
- mode  in  1  0 = bypass (centre tap), 1 = convolve.
- shift  in  3  result right-shift, 0..7.
- coef_wr  in  1  shadow coefficient write strobe.
- coef_addr  in  4  tap index 0..8; 9..15 ignored.
- coef_data  in  COEF_W  coefficient value.
- coef_commit  in  1  copy shadow bank to active bank.

Function
REQ-005 SHALL be a 3-stage pipeline: S1 per-tap multiply, S2 per-channel adder tree, S3 round/shift/saturate into output register; latency 3 accepted cycles.
REQ-006 SHALL advance all stages together when en = ~out_valid | out_ready; in_ready = en; no window lost or duplicated under back-pressure; order preserved.
REQ-007 SHALL carry a valid bit per stage; bubbles (in_valid=0) propagate as invalid.
REQ-008 SHALL sample active coefficients, mode and shift at S1 acceptance and carry them with the data.
REQ-009 SHALL compute per channel sum = Σ coef[k]*tap[k] as signed, width CH_W+COEF_W+4, no intermediate overflow.
REQ-010 SHALL, for shift s>0, add 2^(s-1) then arithmetic-shift right by s; s=0 unmodified.
REQ-011 SHALL saturate each channel to [0, 2^CH_W-1] and set sat_flag if any channel clipped at either bound.
REQ-012 SHALL, in bypass, output centre tap unchanged with the same latency and handshake, sat_flag=0.
REQ-013 SHALL write coef_data to shadow[coef_addr] on coef_wr; addr>8 is a no-op.
REQ-014 SHALL copy shadow to active on coef_commit; windows accepted in the commit cycle or later use the new bank, earlier ones use the old.
REQ-015 SHALL, on coef_wr and coef_commit in the same cycle, commit the shadow bank including that write.
REQ-016 SHALL hold out_pixel and sat_flag stable while out_valid & ~out_ready.

Reset
REQ-017 SHALL on reset clear all stage valids, out_valid, out_pixel and sat_flag to 0.
REQ-018 SHALL on reset load both banks with identity kernel (tap 4 = 1, others 0).
REQ-019 SHALL on reset mid-stream discard all in-flight windows; first output after release is from the first window accepted after release.

Structure
REQ-020 SHALL place tap index constants (TAP_UL..TAP_DR), mode encodings and the identity-kernel constant in shared package conv_filter_pkg.
REQ-021 SHALL implement S3 per channel in sub-module conv_sat_round (signed sum, shift -> CH_W result, clip flag), instantiated NCH times.

Verification (CH_W=4, NCH=3, COEF_W=5)
REQ-022 SHALL check reset default: mode=1, shift=0, centre 0xA53, other taps 0xFFF -> out_pixel 0xA53, sat_flag=0, 3 cycles after acceptance.
REQ-023 SHALL check sharpen (eight taps -1, centre 9, committed): all taps 0x777 -> 0x777; centre 0xF00, others 0x000 -> red 135 -> 0xF00, sat_flag=1; centre 0x000, others 0xFFF -> 0x000, sat_flag=1.
REQ-024 SHALL check blur (all taps 1, shift=3): all taps 0x888 -> sum 72 -> 0x999, sat_flag=0.
REQ-025 SHALL check back-pressure: 6 back-to-back windows, out_ready low for 5 cycles mid-stream -> in_ready drops, exactly 6 outputs, input order, values per REQ-009..011.
REQ-026 SHALL check commit boundary: window A accepted one cycle before coef_commit, window B in the commit cycle -> A uses old kernel, B uses new.
REQ-027 SHALL check reset mid-stream: reset asserted with 3 windows in flight -> out_valid=0 while reset is asserted, no stale outputs afterwards, identity kernel restored.
